// File: rtl/mips_mmio_pkg.sv
// Shared definitions for the data-memory / MMIO bridge: register offsets,
// status/control bit positions and the UART transmitter state encoding.
package mips_mmio_pkg;

    localparam logic [2:0] OFF_UART_DATA = 3'd0;
    localparam logic [2:0] OFF_UART_STAT = 3'd1;
    localparam logic [2:0] OFF_TMR_COUNT = 3'd2;
    localparam logic [2:0] OFF_TMR_CMP   = 3'd3;
    localparam logic [2:0] OFF_TMR_CTRL  = 3'd4;

    localparam int STAT_EMPTY = 0;
    localparam int STAT_FULL  = 1;
    localparam int STAT_BUSY  = 2;
    localparam int STAT_OVF   = 3;

    localparam int CTRL_EN  = 0;
    localparam int CTRL_IRQ = 1;

    typedef enum logic [1:0] {
        UART_IDLE  = 2'd0,
        UART_START = 2'd1,
        UART_DATA  = 2'd2,
        UART_STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/mmio_uart_tx.sv
// Buffered 8N1 transmitter: byte FIFO feeding a start/data/stop shift FSM,
// each bit held for CLKS_PER_BIT clocks; frames run back to back while data waits.
module mmio_uart_tx
    import mips_mmio_pkg::*;
#(
    parameter int FIFO_DEPTH   = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       push,
    input  logic [7:0] din,
    output logic       full,
    output logic       empty,
    output logic       busy,
    output logic       drop,
    output logic       tx
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(CLKS_PER_BIT);

    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    uart_state_e   state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          baud_last, pop, push_ok;
    logic [7:0]    head;

    // push is a one-cycle strobe with no ready: it is accepted when a slot is
    // free or the head leaves in the same cycle, otherwise refused and flagged on drop.
    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign baud_last = (baud_q == BW'(CLKS_PER_BIT - 1));
    assign pop       = !empty && ((state_q == UART_IDLE) || ((state_q == UART_STOP) && baud_last));
    assign push_ok   = push && (!full || pop);
    assign drop      = push && !push_ok;
    assign head      = fifo_mem[rd_ptr_q[AW-1:0]];
    assign busy      = (state_q != UART_IDLE);

    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wr_ptr_q[AW-1:0]] <= din;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        if (pop)     rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        case (state_q)
            UART_IDLE: begin
                if (!empty) begin
                    shift_d = head;
                    baud_d  = '0;
                    state_d = UART_START;
                end
            end
            UART_START: begin
                if (baud_last) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    state_d = UART_DATA;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            UART_DATA: begin
                if (baud_last) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) state_d = UART_STOP;
                    else               bit_d   = bit_q + 3'd1;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            UART_STOP: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (!empty) begin
                        shift_d = head;
                        state_d = UART_START;
                    end else begin
                        state_d = UART_IDLE;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            default: state_d = UART_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            state_q  <= UART_IDLE;
            baud_q   <= '0;
            bit_q    <= 3'd0;
            shift_q  <= 8'h00;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
        end
    end

    // Line level decoded from state so an async reset returns it high at once.
    always_comb begin
        tx = 1'b1;
        if (state_q == UART_START)     tx = 1'b0;
        else if (state_q == UART_DATA) tx = shift_q[0];
    end

endmodule

// File: rtl/dmem_mmio_bridge.sv
// Single-cycle data memory for the MIPS core: word RAM, UART TX and compare
// timer behind a small MMIO window; loads are combinational, stores on posedge.
module dmem_mmio_bridge
    import mips_mmio_pkg::*;
#(
    parameter int          RAM_DEPTH    = 256,
    parameter int          ADDR_W       = 8,
    parameter int          FIFO_DEPTH   = 8,
    parameter int          CLKS_PER_BIT = 16,
    parameter logic [31:0] MMIO_BASE    = 32'h0000_FF00
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    input  logic        MemRead,
    output logic [31:0] ReadData,
    output logic        uart_tx,
    output logic        timer_irq
);

    logic [31:0] ram_q [RAM_DEPTH];
    logic [31:0] mmio_off;
    logic [2:0]  reg_sel;
    logic        is_ram, is_mmio;
    logic        wr_data, wr_stat, wr_count, wr_cmp, wr_ctrl;
    logic [31:0] count_q, count_d, cmp_q, cmp_d;
    logic        enable_q, enable_d, irq_q, irq_d, ovf_q, ovf_d;
    logic        timer_match;
    logic        uart_full, uart_empty, uart_busy, uart_drop;
    logic [31:0] rdata;

    // Addresses below MMIO_BASE wrap to huge offsets, so one compare bounds the window.
    assign is_ram   = ((Address >> ADDR_W) == 32'd0);
    assign mmio_off = Address - MMIO_BASE;
    assign is_mmio  = (mmio_off < 32'd5);
    assign reg_sel  = mmio_off[2:0];

    assign wr_data  = MemWrite && is_mmio && (reg_sel == OFF_UART_DATA);
    assign wr_stat  = MemWrite && is_mmio && (reg_sel == OFF_UART_STAT);
    assign wr_count = MemWrite && is_mmio && (reg_sel == OFF_TMR_COUNT);
    assign wr_cmp   = MemWrite && is_mmio && (reg_sel == OFF_TMR_CMP);
    assign wr_ctrl  = MemWrite && is_mmio && (reg_sel == OFF_TMR_CTRL);

    always_ff @(posedge clk) begin
        if (MemWrite && is_ram) ram_q[Address[ADDR_W-1:0]] <= WriteData;
    end

    assign timer_match = enable_q && (count_q == cmp_q);

    always_comb begin
        count_d  = count_q;
        cmp_d    = cmp_q;
        enable_d = enable_q;
        irq_d    = irq_q;
        ovf_d    = ovf_q;
        if (enable_q) count_d = timer_match ? 32'd0 : count_q + 32'd1;
        if (wr_count) count_d = WriteData;
        if (wr_cmp)   cmp_d   = WriteData;
        if (wr_ctrl)  enable_d = WriteData[CTRL_EN];
        // A match in the same cycle as a clear wins: the event must not be lost.
        if (wr_ctrl && WriteData[CTRL_IRQ]) irq_d = 1'b0;
        if (timer_match)                    irq_d = 1'b1;
        if (wr_stat)   ovf_d = 1'b0;
        if (uart_drop) ovf_d = 1'b1;
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            count_q  <= 32'd0;
            cmp_q    <= 32'hFFFF_FFFF;
            enable_q <= 1'b0;
            irq_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            count_q  <= count_d;
            cmp_q    <= cmp_d;
            enable_q <= enable_d;
            irq_q    <= irq_d;
            ovf_q    <= ovf_d;
        end
    end

    always_comb begin
        rdata = 32'd0;
        if (MemRead) begin
            if (is_ram) begin
                rdata = ram_q[Address[ADDR_W-1:0]];
            end else if (is_mmio) begin
                case (reg_sel)
                    OFF_UART_STAT: begin
                        rdata[STAT_EMPTY] = uart_empty;
                        rdata[STAT_FULL]  = uart_full;
                        rdata[STAT_BUSY]  = uart_busy;
                        rdata[STAT_OVF]   = ovf_q;
                    end
                    OFF_TMR_COUNT: rdata = count_q;
                    OFF_TMR_CMP:   rdata = cmp_q;
                    OFF_TMR_CTRL: begin
                        rdata[CTRL_EN]  = enable_q;
                        rdata[CTRL_IRQ] = irq_q;
                    end
                    default: rdata = 32'd0;
                endcase
            end
        end
    end

    assign ReadData  = rdata;
    assign timer_irq = irq_q;

    mmio_uart_tx #(
        .FIFO_DEPTH  (FIFO_DEPTH),
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart (
        .clk  (clk),
        .Reset(Reset),
        .push (wr_data),
        .din  (WriteData[7:0]),
        .full (uart_full),
        .empty(uart_empty),
        .busy (uart_busy),
        .drop (uart_drop),
        .tx   (uart_tx)
    );

endmodule

// File: tb/tb_dmem_mmio_bridge.sv
// Bench for dmem_mmio_bridge: RAM/decode, UART framing and FIFO overflow,
// compare timer and priorities, asynchronous reset in the middle of activity.
module tb_dmem_mmio_bridge;

    localparam int          CPB   = 16;
    localparam int          FRAME = 10 * CPB;
    localparam logic [31:0] BASE  = 32'h0000_FF00;
    localparam logic [31:0] A_DATA  = BASE;
    localparam logic [31:0] A_STAT  = BASE + 32'd1;
    localparam logic [31:0] A_COUNT = BASE + 32'd2;
    localparam logic [31:0] A_CMP   = BASE + 32'd3;
    localparam logic [31:0] A_CTRL  = BASE + 32'd4;

    logic        clk = 1'b0;
    logic        Reset;
    logic [31:0] Address, WriteData;
    logic        MemWrite, MemRead;
    wire  [31:0] ReadData;
    wire         uart_tx, timer_irq;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  exp_q[$];
    logic [31:0] rd;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got no end, required end");
        $fatal(1, "watchdog");
    end

    dmem_mmio_bridge #(
        .RAM_DEPTH(256), .ADDR_W(8), .FIFO_DEPTH(8), .CLKS_PER_BIT(CPB), .MMIO_BASE(BASE)
    ) dut (
        .clk(clk), .Reset(Reset), .Address(Address), .WriteData(WriteData),
        .MemWrite(MemWrite), .MemRead(MemRead), .ReadData(ReadData),
        .uart_tx(uart_tx), .timer_irq(timer_irq)
    );

    // ---------------- driver tasks (entered just after a negedge) ----------------
    task automatic cpu_write(input logic [31:0] a, input logic [31:0] d);
        Address = a; WriteData = d; MemWrite = 1'b1; MemRead = 1'b0;
        @(negedge clk);
        MemWrite = 1'b0;
    endtask

    task automatic cpu_read(input logic [31:0] a, output logic [31:0] d);
        Address = a; MemRead = 1'b1; MemWrite = 1'b0;
        #1;
        d = ReadData;
        MemRead = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Expected line level at sample j of a frame carrying byte b.
    function automatic logic frame_bit(input logic [7:0] b, input int j);
        int slot;
        slot = j / CPB;
        if (slot == 0) return 1'b0;
        if (slot == 9) return 1'b1;
        return b[slot-1];
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset;
        Reset = 1'b1; Address = '0; WriteData = '0; MemWrite = 1'b0; MemRead = 1'b0;
        idle(3);
        n_checks++; if (uart_tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b want 1", uart_tx); end
        n_checks++; if (timer_irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b want 0", timer_irq); end
        cpu_read(A_STAT, rd);
        n_checks++; if (rd !== 32'h1) begin n_fail++; $display("FAIL reset_stat: got %h want 00000001", rd); end
        cpu_read(A_COUNT, rd);
        n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL reset_count: got %h want 0", rd); end
        cpu_read(A_CMP, rd);
        n_checks++; if (rd !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL reset_cmp: got %h want ffffffff", rd); end
        cpu_read(A_CTRL, rd);
        n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL reset_ctrl: got %h want 0", rd); end
        @(negedge clk);
        Reset = 1'b0;
        idle(1);
    endtask

    task automatic test_ram;
        cpu_write(32'd5, 32'hDEAD_BEEF);
        cpu_read(32'd5, rd);
        n_checks++; if (rd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL ram_read5: got %h want deadbeef", rd); end
        Address = 32'd5; MemRead = 1'b0; #1;
        n_checks++; if (ReadData !== 32'h0) begin n_fail++; $display("FAIL ram_noread: got %h want 0", ReadData); end
        @(negedge clk);
        Address = 32'd5; WriteData = 32'h1234_5678; MemWrite = 1'b1; MemRead = 1'b1; #1;
        n_checks++; if (ReadData !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL ram_rw_prewrite: got %h want deadbeef", ReadData); end
        @(negedge clk);
        MemWrite = 1'b0; #1;
        n_checks++; if (ReadData !== 32'h1234_5678) begin n_fail++; $display("FAIL ram_rw_after: got %h want 12345678", ReadData); end
        MemRead = 1'b0;
        cpu_write(32'd300, 32'hCAFE_F00D);
        cpu_read(32'd300, rd);
        n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL hole_300: got %h want 0", rd); end
        cpu_read(BASE + 32'd5, rd);
        n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL hole_base5: got %h want 0", rd); end
        cpu_read(BASE - 32'd1, rd);
        n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL hole_below_base: got %h want 0", rd); end
        cpu_read(A_DATA, rd);
        n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL uart_data_read: got %h want 0", rd); end
    endtask

    task automatic test_ram_random;
        logic [31:0] ram_m [256];
        bit          ram_v [256];
        logic [31:0] written[$];
        logic [31:0] a, d, want;
        for (int i = 0; i < 256; i++) ram_v[i] = 1'b0;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0:       a = $urandom_range(32'hFEFF, 256);
                1:       a = $urandom() | 32'h0001_0000;
                default: a = $urandom_range(255, 0);
            endcase
            d = $urandom();
            cpu_write(a, d);
            if (a < 32'd256) begin ram_m[a] = d; ram_v[a] = 1'b1; end
            written.push_back(a);
        end
        for (int i = 0; i < 40; i++) begin
            a = written[$urandom_range(written.size() - 1, 0)];
            want = (a < 32'd256) ? ram_m[a] : 32'h0;
            cpu_read(a, rd);
            n_checks++;
            if (rd !== want) begin n_fail++; $display("FAIL ram_random @%h: got %h want %h", a, rd, want); end
            @(negedge clk);
        end
    endtask

    task automatic test_uart_frame;
        logic [7:0] cur;
        exp_q.push_back(8'hA5);
        cpu_write(A_DATA, 32'h0000_00A5);
        for (int i = 0; i <= FRAME; i++) begin
            logic want_tx;
            want_tx = 1'b1;
            if (i >= 1) begin
                if (i == 1) cur = exp_q.pop_front();
                want_tx = frame_bit(cur, i - 1);
            end
            n_checks++;
            if (uart_tx !== want_tx) begin n_fail++; $display("FAIL frame_a5 sample %0d: got %b want %b", i, uart_tx, want_tx); end
            cpu_read(A_STAT, rd);
            n_checks++;
            if (rd[2] !== (i >= 1)) begin n_fail++; $display("FAIL frame_busy sample %0d: got %b want %b", i, rd[2], (i >= 1)); end
            @(negedge clk);
        end
        cpu_read(A_STAT, rd);
        n_checks++; if (rd !== 32'h1) begin n_fail++; $display("FAIL frame_stat_after: got %h want 00000001", rd); end
        n_checks++; if (uart_tx !== 1'b1) begin n_fail++; $display("FAIL frame_idle_tx: got %b want 1", uart_tx); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] bytes [10];
        logic [7:0] cur;
        int         j;
        logic       want_tx;
        for (int i = 0; i < 10; i++) begin
            bytes[i] = 8'($urandom());
            if (i < 9) exp_q.push_back(bytes[i]);
        end
        for (int k = 0; k <= 2 + 9 * FRAME; k++) begin
            if (k > 0) @(negedge clk);
            want_tx = 1'b1;
            if (k >= 2 && k < 2 + 9 * FRAME) begin
                j = k - 2;
                if (j % FRAME == 0) cur = exp_q.pop_front();
                want_tx = frame_bit(cur, j % FRAME);
            end
            n_checks++;
            if (uart_tx !== want_tx) begin n_fail++; $display("FAIL b2b_tx k=%0d: got %b want %b", k, uart_tx, want_tx); end
            if (k < 10) begin
                Address = A_DATA; WriteData = {24'h0, bytes[k]}; MemWrite = 1'b1; MemRead = 1'b0;
            end else begin
                MemWrite = 1'b0;
                if (k == 10) begin
                    cpu_read(A_STAT, rd);
                    n_checks++; if (rd !== 32'hE) begin n_fail++; $display("FAIL b2b_stat_full: got %h want 0000000e", rd); end
                end else if (k == 2 + 9 * FRAME) begin
                    cpu_read(A_STAT, rd);
                    n_checks++; if (rd !== 32'h9) begin n_fail++; $display("FAIL b2b_stat_done: got %h want 00000009", rd); end
                end
            end
        end
        @(negedge clk);
        cpu_write(A_STAT, 32'h0);
        cpu_read(A_STAT, rd);
        n_checks++; if (rd !== 32'h1) begin n_fail++; $display("FAIL ovf_clear: got %h want 00000001", rd); end
    endtask

    task automatic test_timer;
        logic [31:0] mc;
        logic        mirq;
        cpu_write(A_CTRL, 32'h0);
        cpu_write(A_COUNT, 32'h0);
        cpu_write(A_CMP, 32'd3);
        cpu_write(A_CTRL, 32'd1);
        mc = 32'd0; mirq = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cpu_read(A_COUNT, rd);
            n_checks++; if (rd !== mc) begin n_fail++; $display("FAIL timer_count step %0d: got %h want %h", i, rd, mc); end
            n_checks++; if (timer_irq !== mirq) begin n_fail++; $display("FAIL timer_irq step %0d: got %b want %b", i, timer_irq, mirq); end
            @(negedge clk);
            if (mc == 32'd3) begin mc = 32'd0; mirq = 1'b1; end
            else mc = mc + 32'd1;
        end
        cpu_write(A_CMP, 32'd1000);
        cpu_write(A_CTRL, 32'd3);
        n_checks++; if (timer_irq !== 1'b0) begin n_fail++; $display("FAIL timer_w1c: got %b want 0", timer_irq); end
        cpu_read(A_CTRL, rd);
        n_checks++; if (rd !== 32'h1) begin n_fail++; $display("FAIL timer_ctrl_after_w1c: got %h want 00000001", rd); end
        cpu_write(A_CTRL, 32'h0);
        cpu_write(A_COUNT, 32'hFFFF_FFFF);
        cpu_write(A_CMP, 32'd5);
        cpu_write(A_CTRL, 32'd1);
        mc = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            cpu_read(A_COUNT, rd);
            n_checks++; if (rd !== mc) begin n_fail++; $display("FAIL timer_wrap step %0d: got %h want %h", i, rd, mc); end
            n_checks++; if (timer_irq !== 1'b0) begin n_fail++; $display("FAIL timer_wrap_irq step %0d: got %b want 0", i, timer_irq); end
            @(negedge clk);
            mc = mc + 32'd1;
        end
    endtask

    task automatic test_priority;
        cpu_write(A_CTRL, 32'd2);
        cpu_write(A_COUNT, 32'd0);
        cpu_write(A_CMP, 32'd3);
        cpu_write(A_CTRL, 32'd1);
        idle(3);
        cpu_read(A_COUNT, rd);
        n_checks++; if (rd !== 32'd3) begin n_fail++; $display("FAIL prio_pre_count: got %h want 3", rd); end
        n_checks++; if (timer_irq !== 1'b0) begin n_fail++; $display("FAIL prio_pre_irq: got %b want 0", timer_irq); end
        cpu_write(A_CTRL, 32'd3);
        n_checks++; if (timer_irq !== 1'b1) begin n_fail++; $display("FAIL prio_set_beats_w1c: got %b want 1", timer_irq); end
        cpu_read(A_COUNT, rd);
        n_checks++; if (rd !== 32'd0) begin n_fail++; $display("FAIL prio_match_count: got %h want 0", rd); end
        idle(3);
        cpu_write(A_COUNT, 32'd100);
        cpu_read(A_COUNT, rd);
        n_checks++; if (rd !== 32'd100) begin n_fail++; $display("FAIL prio_write_beats_match: got %h want 100", rd); end
        @(negedge clk);
        cpu_read(A_COUNT, rd);
        n_checks++; if (rd !== 32'd101) begin n_fail++; $display("FAIL prio_count_continues: got %h want 101", rd); end
    endtask

    task automatic test_reset_mid;
        cpu_write(A_DATA, 32'h0000_003C);
        idle(40);
        #2 Reset = 1'b1;
        #1;
        n_checks++; if (uart_tx !== 1'b1) begin n_fail++; $display("FAIL rst_mid_tx: got %b want 1", uart_tx); end
        n_checks++; if (timer_irq !== 1'b0) begin n_fail++; $display("FAIL rst_mid_irq: got %b want 0", timer_irq); end
        cpu_read(A_STAT, rd);
        n_checks++; if (rd !== 32'h1) begin n_fail++; $display("FAIL rst_mid_stat: got %h want 00000001", rd); end
        cpu_read(A_COUNT, rd);
        n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL rst_mid_count: got %h want 0", rd); end
        @(negedge clk);
        Reset = 1'b0;
        idle(3);
        n_checks++; if (uart_tx !== 1'b1) begin n_fail++; $display("FAIL rst_fifo_lost_tx: got %b want 1", uart_tx); end
        cpu_read(A_STAT, rd);
        n_checks++; if (rd !== 32'h1) begin n_fail++; $display("FAIL rst_fifo_lost_stat: got %h want 00000001", rd); end
        cpu_read(A_COUNT, rd);
        n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL rst_timer_frozen: got %h want 0", rd); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset;
        test_ram;
        test_ram_random;
        test_uart_frame;
        test_back_to_back;
        test_timer;
        test_priority;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
